div_iter_param: RTL and testbench

// - Parametrised iterative non-restoring divider for the CPU54 datapath. Sits beside the multiplier and feeds HI/LO.
// - Per-operation signed or unsigned mode (DIV/DIVU), explicit done pulse, defined divide-by-zero and overflow results.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_iter_param_if.sv | 24 ++
 rtl/div_step.sv | 21 ++
 rtl/div_iter_param.sv | 143 ++++++++++++++
 tb/tb_div_iter_param.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  localparam int DIV_MAX_W = 64;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX
  } div_state_t;

  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

  // Callers zero-extend into DIV_MAX_W and truncate back; negation is width-agnostic mod 2^n.
  function automatic logic [DIV_MAX_W-1:0] abs_w(input logic [DIV_MAX_W-1:0] v,
                                                 input logic               neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter_param_if.sv
// Request/result bundle between the datapath and the divider.
interface div_iter_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, q, r, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, q, r, div_zero
  );
endinterface

// File: rtl/div_step.sv
// One non-restoring add/sub step on a WIDTH+1-bit partial remainder (combinational).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             a_msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] b_ext;

  assign p_sh  = {p_i[WIDTH-1:0], a_msb_i};
  assign b_ext = {1'b0, b_i};
  // Intermediate may wrap, but the post-step remainder always lies in [-B, B).
  assign p_o     = p_i[WIDTH] ? (p_sh + b_ext) : (p_sh - b_ext);
  assign q_bit_o = ~p_o[WIDTH];

endmodule

// File: rtl/div_iter_param.sv
// Iterative signed/unsigned non-restoring divider, state changes on falling clock edge.
// DIV_FAST_EN: skip the iteration phase when divisor==0 or |dividend|<|divisor|.
module div_iter_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  div_iter_param_if.slave bus
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   p_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             zero_q;
  logic             skip_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dz_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             div0;
  logic             skip_d;
  logic [WIDTH:0]   p_step;
  logic             q_bit;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] r_d;

  assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_abs = WIDTH'(abs_w(DIV_MAX_W'(bus.dividend), a_neg));
  assign b_abs = WIDTH'(abs_w(DIV_MAX_W'(bus.divisor), b_neg));
  assign div0  = (bus.divisor == '0);

`ifdef DIV_FAST_EN
  assign skip_d = div0 | (a_abs < b_abs);
`else
  assign skip_d = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (p_q),
    .a_msb_i (a_q[WIDTH-1]),
    .b_i     (b_q),
    .p_o     (p_step),
    .q_bit_o (q_bit)
  );

  // Final restore: the remainder magnitude fits WIDTH bits once corrected.
  assign rem = p_q[WIDTH] ? (p_q[WIDTH-1:0] + b_q) : p_q[WIDTH-1:0];

  always_comb begin
    q_d = q_neg_q ? -a_q : a_q;
    r_d = r_neg_q ? -rem : rem;
    if (skip_q) begin
      q_d = '0;
      r_d = dvd_q;
    end
    if (zero_q) begin
      q_d = WIDTH'(DIV_ZERO_Q);
      r_d = dvd_q;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      p_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      skip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (bus.start) begin
            a_q     <= a_abs;
            b_q     <= b_abs;
            dvd_q   <= bus.dividend;
            p_q     <= '0;
            cnt_q   <= '0;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            zero_q  <= div0;
            skip_q  <= skip_d;
            busy_q  <= 1'b1;
            state_q <= skip_d ? DIV_FIX : DIV_RUN;
          end
        end
        DIV_RUN: begin
          p_q   <= p_step;
          a_q   <= {a_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          q_q     <= q_d;
          r_q     <= r_d;
          dz_q    <= zero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param: 32-bit and 8-bit instances, falling-edge DUT, sampling after each edge.
module tb_div_iter_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_FAST_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  always #5 clk = ~clk;

  div_iter_param_if #(.WIDTH(32)) bus32 ();
  div_iter_param_if #(.WIDTH(8))  bus8 ();

  div_iter_param #(.WIDTH(32)) dut32 (.clock(clk), .reset(rst), .bus(bus32));
  div_iter_param #(.WIDTH(8))  dut8  (.clock(clk), .reset(rst), .bus(bus8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op32(input string tag, input logic sgn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                      input logic edz, input int elat);
    int   n;
    logic seen;
    @(posedge clk);
    bus32.start     = 1'b1;
    bus32.is_signed = sgn;
    bus32.dividend  = a;
    bus32.divisor   = b;
    @(negedge clk); #1;
    bus32.start = 1'b0;
    chk({tag, "_busy_acc"}, 32'(bus32.busy), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); #1;
      n++;
      seen = bus32.done;
    end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_q"}, bus32.q, eq);
    chk({tag, "_r"}, bus32.r, er);
    chk({tag, "_dz"}, 32'(bus32.div_zero), 32'(edz));
    chk({tag, "_busy_done"}, 32'(bus32.busy), 32'd0);
  endtask

  initial begin
    int   n;
    int   dcnt;
    logic seen;

    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus32.busy), 32'd0);
    chk("rst_done", 32'(bus32.done), 32'd0);
    chk("rst_q", bus32.q, 32'd0);
    chk("rst_r", bus32.r, 32'd0);
    chk("rst_dz", 32'(bus32.div_zero), 32'd0);
    chk("rst_busy8", 32'(bus8.busy), 32'd0);
    @(posedge clk);
    rst = 1'b0;

    op32("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    op32("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    op32("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    op32("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    op32("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0,
         (FAST != 0) ? 1 : 33);
    op32("s_div_2", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    op32("dz", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, (FAST != 0) ? 1 : 33);

    // Results hold after done
    repeat (3) @(negedge clk);
    #1;
    chk("hold_dz", 32'(bus32.div_zero), 32'd1);
    chk("hold_r", bus32.r, 32'h1234);
    chk("hold_done", 32'(bus32.done), 32'd0);

    // start while busy with other operands is ignored
    @(posedge clk);
    bus32.start = 1'b1; bus32.is_signed = 1'b0; bus32.dividend = 32'd1000; bus32.divisor = 32'd10;
    @(negedge clk); #1;
    bus32.start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    bus32.start = 1'b1; bus32.is_signed = 1'b1; bus32.dividend = 32'd5; bus32.divisor = 32'd5;
    @(negedge clk); #1;
    bus32.start = 1'b0;
    n = 5;
    seen = bus32.done;
    while (!seen && n < 100) begin
      @(negedge clk); #1;
      n++;
      seen = bus32.done;
    end
    chk("ign_lat", n, 33);
    chk("ign_q", bus32.q, 32'd100);
    chk("ign_r", bus32.r, 32'd0);
    @(negedge clk); #1;
    chk("ign_idle", 32'(bus32.busy), 32'd0);

    // Reset in the middle of an op aborts it
    @(posedge clk);
    bus32.start = 1'b1; bus32.is_signed = 1'b0; bus32.dividend = 32'd100; bus32.divisor = 32'd7;
    @(negedge clk); #1;
    bus32.start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(bus32.busy), 32'd0);
    chk("mid_q", bus32.q, 32'd0);
    chk("mid_r", bus32.r, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus32.done) dcnt++;
    end
    chk("mid_nodone", dcnt, 0);

    // 8-bit instance: start held high gives back-to-back ops
    @(posedge clk);
    bus8.start = 1'b1; bus8.is_signed = 1'b0; bus8.dividend = 8'd200; bus8.divisor = 8'd3;
    @(negedge clk); #1;
    bus8.dividend = 8'd50; bus8.divisor = 8'd7;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); #1;
      n++;
      seen = bus8.done;
    end
    chk("w8_lat", n, 9);
    chk("w8_q", 32'(bus8.q), 32'd66);
    chk("w8_r", 32'(bus8.r), 32'd2);
    @(negedge clk); #1;
    bus8.start = 1'b0;
    chk("w8_b2b_busy", 32'(bus8.busy), 32'd1);
    chk("w8_b2b_done", 32'(bus8.done), 32'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); #1;
      n++;
      seen = bus8.done;
    end
    chk("w8_b2b_lat", n, 9);
    chk("w8_b2b_q", 32'(bus8.q), 32'd7);
    chk("w8_b2b_r", 32'(bus8.r), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
